// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mult_div_unit
// Brief   : Iterative WIDTH-bit multiply (low half) / unsigned divide /
//           signed divide with a start/busy/done handshake. One bit is
//           processed per cycle, so every operation takes WIDTH cycles.
// Revision: 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done
);

  localparam int             CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam logic [1:0]     OP_MUL  = 2'b00;
  localparam logic [1:0]     OP_UDIV = 2'b01;
  localparam logic [1:0]     OP_SDIV = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;       // MUL: shifted multiplicand; DIV: dividend in, quotient out
  logic [WIDTH-1:0] b_q, b_d;       // MUL: shifted multiplier;   DIV: divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d;   // MUL: partial product;      DIV: partial remainder
  logic             neg_q, neg_d;   // SDIV: quotient must be negated
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_rem_sub;
  logic             w_qbit;
  logic [WIDTH-1:0] w_it_a, w_it_b, w_it_acc;
  logic [WIDTH-1:0] w_final;

  // One iteration of the datapath: shift-add for MUL, restoring step for DIV
  always_comb begin
    w_rem_sh  = {acc_q, a_q[WIDTH-1]};
    w_qbit    = (w_rem_sh >= {1'b0, b_q});
    // Bit WIDTH of the shifted remainder is cancelled whenever w_qbit is set,
    // so the low WIDTH bits of the difference are exact.
    w_rem_sub = w_rem_sh[WIDTH-1:0] - b_q;
    if (op_q == OP_MUL) begin
      w_it_acc = acc_q + (b_q[0] ? a_q : '0);
      w_it_a   = a_q << 1;
      w_it_b   = b_q >> 1;
    end else begin
      w_it_acc = w_qbit ? w_rem_sub : w_rem_sh[WIDTH-1:0];
      w_it_a   = {a_q[WIDTH-2:0], w_qbit};
      w_it_b   = b_q;
    end
    case (op_q)
      OP_MUL:  w_final = w_it_acc;
      OP_UDIV: w_final = (b_q == '0) ? '0 : w_it_a;
      OP_SDIV: w_final = (b_q == '0) ? '0 : (neg_q ? -w_it_a : w_it_a);
      default: w_final = '0;
    endcase
  end

  // Next-state logic for the IDLE/RUN/FIN controller and operand registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (Start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = Op;
          acc_d   = '0;
          if (Op == OP_SDIV) begin
            a_d   = BusA[WIDTH-1] ? -BusA : BusA;
            b_d   = BusB[WIDTH-1] ? -BusB : BusB;
            neg_d = BusA[WIDTH-1] ^ BusB[WIDTH-1];
          end else begin
            a_d   = BusA;
            b_d   = BusB;
            neg_d = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = w_it_a;
        b_d   = w_it_b;
        acc_d = w_it_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = S_FIN;
          result_d = w_final;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FIN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Result = result_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mult_div_unit
// Brief   : Self-checking bench for mult_div_unit: vector table plus
//           hand-written handshake/reset sequences, with a result queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] bus_a, bus_b;
  logic [W-1:0] result;
  logic         busy, done;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc_cnt  = 0;
  int busy_n   = 0;
  logic [W-1:0] sb[$];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[13];

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk    (clk),
    .Reset  (rst),
    .Start  (start),
    .Op     (op),
    .BusA   (bus_a),
    .BusB   (bus_b),
    .Result (result),
    .Busy   (busy),
    .Done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc_cnt++;
    if (busy) busy_n++;
  endtask

  // Present an operation with Start high for exactly one accepted edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp);
    op    = o;
    bus_a = a;
    bus_b = b;
    start = 1'b1;
    sb.push_back(exp);
    cyc_cnt = 0;
    busy_n  = 0;
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for Done, then check latency, busy length and result.
  task automatic finish(input string name);
    logic [W-1:0] exp;
    while (!done && cyc_cnt < 200) step();
    check({name, "_latency"}, W'(cyc_cnt), W'(W + 1));
    check({name, "_busycyc"}, W'(busy_n), W'(W));
    if (sb.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s_sb: got empty queue, expected an entry", name);
    end else begin
      exp = sb.pop_front();
      check({name, "_result"}, result, exp);
    end
  endtask

  initial begin
    tbl[0]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[1]  = '{2'b00, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0};
    tbl[2]  = '{2'b00, 64'd123456789, 64'd987654321, 64'd121932631112635269};
    tbl[3]  = '{2'b01, 64'd100, 64'd7, 64'd14};
    tbl[4]  = '{2'b01, 64'h8000_0000_0000_0000, 64'd2, 64'h4000_0000_0000_0000};
    tbl[5]  = '{2'b01, 64'd5, 64'd0, 64'd0};
    tbl[6]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
    tbl[7]  = '{2'b10, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD};
    tbl[8]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3};
    tbl[9]  = '{2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    tbl[10] = '{2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd0, 64'd0};
    tbl[11] = '{2'b11, 64'd9, 64'd3, 64'd0};
    tbl[12] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'h1999_9999_9999_9999};

    // Reset held with Start high: nothing may start, outputs stay clear.
    rst   = 1'b1;
    start = 1'b1;
    op    = 2'b00;
    bus_a = 64'd3;
    bus_b = 64'd5;
    repeat (3) step();
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_result", result, '0);

    // Release reset with Start still high: first edge accepts MUL 3*5.
    rst = 1'b0;
    issue(2'b00, 64'd3, 64'd5, 64'd15);
    check("first_busy", W'(busy), W'(1));
    finish("mul_3x5");
    step();
    check("mul_3x5_done_drop", W'(done), '0);

    // Table of vectors.
    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
      finish($sformatf("vec%0d", i));
      step();
      check($sformatf("vec%0d_done_drop", i), W'(done), '0);
      check($sformatf("vec%0d_idle", i), W'(busy), '0);
      check($sformatf("vec%0d_hold", i), result, tbl[i].exp);
    end

    // Start pulsed mid-run with other operands must be ignored.
    issue(2'b00, 64'd6, 64'd7, 64'd42);
    repeat (9) step();
    op    = 2'b01;
    bus_a = 64'd1000;
    bus_b = 64'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    finish("ignore_start");
    step();
    check("ignore_start_no_restart", W'(busy), '0);

    // Back-to-back: Start in the Done cycle.
    issue(2'b00, 64'd3, 64'd3, 64'd9);
    finish("b2b_first");
    issue(2'b01, 64'd100, 64'd10, 64'd10);
    check("b2b_done_low", W'(done), '0);
    check("b2b_busy_high", W'(busy), W'(1));
    check("b2b_result_held", result, 64'd9);
    finish("b2b_second");

    // Reset mid-operation aborts with no Done pulse.
    issue(2'b00, 64'd12, 64'd12, 64'd144);
    repeat (30) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", W'(busy), '0);
    check("abort_result", result, '0);
    check("abort_done", W'(done), '0);
    sb.delete();
    begin
      int seen = 0;
      for (int i = 0; i < 80; i++) begin
        step();
        if (done || busy) seen++;
      end
      check("abort_no_done", W'(seen), '0);
    end
    issue(2'b00, 64'd6, 64'd7, 64'd42);
    finish("after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 64-bit multiply/divide unit downstream of the register file in the LEGv8 datapath.
- Consumes the BusA/BusB operand values and produces a result for write-back on BusW.
- Implements MUL (low half), UDIV and SDIV with a start/busy/done handshake; the controller stalls the PC while Busy is high.
- Sits in parallel with the ALU; the write-back mux selects Result when Done is high.

Parameters:
- WIDTH, 64, operand/result width; iteration count equals WIDTH.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when Busy=0.
- Op  input  2  00=MUL, 01=UDIV, 10=SDIV, 11=reserved.
- BusA  input  WIDTH  operand A (multiplicand / dividend).
- BusB  input  WIDTH  operand B (multiplier / divisor).
- Result  output  WIDTH  result; held stable from Done until the next accepted Start.
- Busy  output  1  high while iterating.
- Done  output  1  one-cycle pulse when Result becomes valid.

Behaviour:
- Reset, sampled at posedge: state=IDLE, Busy=0, Done=0, Result=0, counter=0, operand registers=0. Reset mid-operation aborts the operation; no Done pulse is produced.
- FSM states: IDLE, RUN, FIN.
  - IDLE/FIN with Start=1: latch Op, BusA and BusB (SDIV latches magnitudes plus sign flags); counter=0; go to RUN.
  - IDLE with Start=0: stay in IDLE.
  - FIN with Start=0: go to IDLE.
  - RUN: one iteration per cycle; counter increments. After iteration WIDTH-1 (counter==WIDTH-1), go to FIN.
  - FIN: Done=1 for exactly this cycle; Result loaded on the transition into FIN.
- Outputs are registered. Busy=1 exactly while in RUN.
- Latency: Start accepted at edge N → Busy=1 in cycles N+1..N+WIDTH → Done=1 and Result valid in cycle N+WIDTH+1 → Done=0 after that unless restarted.
- Back-to-back: Start is accepted in the FIN cycle. The next Busy begins the following cycle, and Done drops.
- Start while Busy=1 is ignored; Op and operands are not re-sampled during RUN.
- MUL: shift-add over the WIDTH bits of B. Result = (A*B) mod 2^WIDTH; signed and unsigned give identical low halves.
- UDIV: restoring divide, one quotient bit per iteration, MSB first. Result = floor(A/B). Remainder is internal only.
- SDIV:
  - Divide |A| by |B| unsigned.
  - Negate the quotient if sign(A) XOR sign(B). Quotient truncates toward zero.
  - Overflow case: most-negative / -1 = most-negative (wraps, no trap).
- Divide by zero (UDIV/SDIV, B==0): Result=0, same latency, no flag.
- Op=11: Result=0, same latency.
- Result is never written by the unit other than on entry to FIN or on Reset.

Test Plan:
- Reset with Start held high, then Reset deasserted with Start=1, Op=00, A=3, B=5 → Busy high 64 cycles, Done pulse in cycle 65, Result=15; Busy=0 and Done=0 during Reset.
- MUL A=0xFFFFFFFFFFFFFFFF, B=2 → Result=0xFFFFFFFFFFFFFFFE. MUL A=0x100000000, B=0x100000000 → Result=0 (truncated).
- UDIV A=100, B=7 → 14. UDIV A=0x8000000000000000, B=2 → 0x4000000000000000. UDIV A=5, B=0 → 0, Done in cycle 65.
- SDIV cases:
  - A=-7, B=2 → -3 (0xFFFFFFFFFFFFFFFD).
  - A=7, B=-2 → -3.
  - A=-7, B=-2 → 3.
  - A=0x8000000000000000, B=-1 → 0x8000000000000000.
- Handshake:
  - Start pulsed at cycle 10 of a run with different operands → ignored, original Result returned.
  - Start asserted in the Done cycle → new op begins, Done low next cycle, second Done 65 cycles later.
- Reset asserted at iteration 30 → Busy=0, Result=0 next cycle, no Done pulse. Subsequent MUL 6×7 → 42.
